// File: rtl/pipe_lsu.sv
// MEM-stage load/store initiator for a word-wide synchronous data RAM: lane extract/extend on loads, RMW on sub-word stores.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of truncating them.
module pipe_lsu #(
   parameter int RAM_AW = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        misalign,
   output logic        ram_ena,
   output logic        ram_wena,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [15:0] r_wdata;

   logic        w_word, w_mis, w_go;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext, w_merge;

   // RAM decodes only [RAM_AW+1:2]; upper bits ride along untouched.
   function automatic logic [31:0] f_waddr(input logic [31:0] a);
      return {a[31:RAM_AW+2], a[RAM_AW+1:2], 2'b00};
   endfunction

   assign w_word = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis = req_valid && ((req_size == 2'b01 && req_addr[0]) ||
                                (w_word && req_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   assign w_go = req_valid && !w_mis;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_wdata  <= '0;
      end else if (r_state == S_IDLE && w_go && !(req_we && w_word)) begin
         r_addr   <= req_addr;
         r_size   <= req_size;
         r_signed <= req_signed;
         r_wdata  <= req_wdata[15:0];
      end
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: if (w_go) begin
            if (!req_we)     w_next = S_LOAD;
            else if (!w_word) w_next = S_RMW;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Lane select and merge, little-endian within the word.
   always_comb begin
      w_byte  = ram_rdata[7:0];
      w_merge = ram_rdata;
      case (r_addr[1:0])
         2'd0: w_byte = ram_rdata[7:0];
         2'd1: w_byte = ram_rdata[15:8];
         2'd2: w_byte = ram_rdata[23:16];
         default: w_byte = ram_rdata[31:24];
      endcase
      w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      if (r_size == 2'b00) begin
         case (r_addr[1:0])
            2'd0: w_merge[7:0]   = r_wdata[7:0];
            2'd1: w_merge[15:8]  = r_wdata[7:0];
            2'd2: w_merge[23:16] = r_wdata[7:0];
            default: w_merge[31:24] = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[31:16] = r_wdata;
      end else begin
         w_merge[15:0] = r_wdata;
      end
      case (r_size)
         2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
         default: w_ext = ram_rdata;
      endcase
   end

   // Outputs are forced quiet for as long as reset is held, even with a live request.
   always_comb begin
      stall     = 1'b0;
      rdata     = '0;
      rvalid    = 1'b0;
      misalign  = 1'b0;
      ram_ena   = 1'b0;
      ram_wena  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rst_n) begin
         case (r_state)
            S_IDLE: begin
               misalign = w_mis;
               if (w_go) begin
                  ram_ena  = 1'b1;
                  ram_addr = f_waddr(req_addr);
                  if (req_we && w_word) begin
                     ram_wena  = 1'b1;
                     ram_wdata = req_wdata;
                  end else begin
                     stall = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               rvalid = 1'b1;
               rdata  = w_ext;
            end
            S_RMW: begin
               ram_ena   = 1'b1;
               ram_wena  = 1'b1;
               ram_addr  = f_waddr(r_addr);
               ram_wdata = w_merge;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_lsu.sv
// Directed bench for pipe_lsu with a behavioural 32-word synchronous RAM attached to the RAM port.
module tb_pipe_lsu;

   logic        clk, rst_n;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, rvalid, misalign, ram_ena, ram_wena;
   logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
   logic [31:0] mem [32];

   int n_cmp = 0;
   int n_err = 0;

   pipe_lsu #(.RAM_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .rvalid(rvalid), .misalign(misalign),
      .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_ena) begin
         if (ram_wena) mem[ram_addr[6:2]] <= ram_wdata;
         else          ram_rdata <= mem[ram_addr[6:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d);
      req_valid = v; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   // Two-cycle load: checks stall in cycle 1 and the extended result in cycle 2.
   task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 1'b0, sz, sg, a, 32'h0);
      mid(); chk({tag, ".stall"}, {31'b0, stall}, 32'd1);
      nxt();
      mid(); chk({tag, ".rvalid"}, {31'b0, rvalid}, 32'd1);
             chk({tag, ".rdata"}, rdata, exp);
      nxt(); idle();
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b1, 2'b10, 1'b0, a, d);
      nxt(); idle();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      ram_rdata = 32'h0;
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
      mid();
      chk("rst.ram_ena",  {31'b0, ram_ena},  32'd0);
      chk("rst.ram_wena", {31'b0, ram_wena}, 32'd0);
      chk("rst.stall",    {31'b0, stall},    32'd0);
      chk("rst.ram_wdata", ram_wdata, 32'h0);
      chk("rst.ram_addr",  ram_addr,  32'h0);
      chk("rst.rdata",     rdata,     32'h0);
      nxt(); rst_n = 1'b1; idle();
      mid(); chk("idle.ram_ena", {31'b0, ram_ena}, 32'd0);
      nxt();

      // word store: single cycle, no stall
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344);
      mid();
      chk("sw.ena",   {30'b0, ram_ena, ram_wena}, 32'd3);
      chk("sw.stall", {31'b0, stall}, 32'd0);
      chk("sw.addr",  ram_addr,  32'h08);
      chk("sw.wdata", ram_wdata, 32'h11223344);
      nxt(); idle();
      load("lw08", 2'b10, 1'b0, 32'h08, 32'h11223344);
      mid(); chk("post.rvalid", {31'b0, rvalid}, 32'd0);
             chk("post.rdata", rdata, 32'h0);
      nxt();

      // sb 0xAA at 0x09
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AA);
      mid();
      chk("sb.c1", {29'b0, stall, ram_ena, ram_wena}, 32'b110);
      nxt();
      mid();
      chk("sb.c2", {29'b0, stall, ram_ena, ram_wena}, 32'b011);
      chk("sb.addr",  ram_addr,  32'h08);
      chk("sb.wdata", ram_wdata, 32'h1122AA44);
      nxt(); idle();
      load("lw08b", 2'b10, 1'b0, 32'h08, 32'h1122AA44);

      // lane extraction and extension
      sw(32'h0C, 32'h80FF7F01);
      load("lb0C",  2'b00, 1'b1, 32'h0C, 32'h00000001);
      load("lb0E",  2'b00, 1'b1, 32'h0E, 32'hFFFFFFFF);
      load("lbu0E", 2'b00, 1'b0, 32'h0E, 32'h000000FF);
      load("lb0D",  2'b00, 1'b1, 32'h0D, 32'h0000007F);
      load("lh0E",  2'b01, 1'b1, 32'h0E, 32'hFFFF80FF);
      load("lhu0C", 2'b01, 1'b0, 32'h0C, 32'h00007F01);

      // sh 0xBEEF at 0x12, upper bits of wdata must not leak in
      sw(32'h10, 32'h11223344);
      drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h5555BEEF);
      nxt();
      mid(); chk("sh.wdata", ram_wdata, 32'hBEEF3344);
      nxt(); idle();
      load("lw10", 2'b10, 1'b0, 32'h10, 32'hBEEF3344);

      // reset during the RMW cycle abandons the write
      sw(32'h14, 32'h55667788);
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h14, 32'h00000099);
      nxt();
      rst_n = 1'b0;
      mid();
      chk("rrst.c2", {29'b0, stall, ram_ena, ram_wena}, 32'b000);
      nxt(); rst_n = 1'b1; idle();
      mid(); chk("rrst.state", {30'b0, stall, rvalid}, 32'd0);
      nxt();
      load("lw14", 2'b10, 1'b0, 32'h14, 32'h55667788);

      // misaligned lw at 0x0D
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0);
      mid();
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis.flag",  {31'b0, misalign}, 32'd1);
      chk("mis.ena",   {31'b0, ram_ena},  32'd0);
      chk("mis.stall", {31'b0, stall},    32'd0);
      nxt(); idle();
      mid(); chk("mis.clear", {30'b0, misalign, rvalid}, 32'd0);
      nxt();
`else
      chk("mis.flag", {31'b0, misalign}, 32'd0);
      chk("mis.addr", ram_addr, 32'h0C);
      chk("mis.stall", {31'b0, stall}, 32'd1);
      nxt();
      mid(); chk("mis.rdata", rdata, 32'h80FF7F01);
      nxt(); idle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
